// File: rtl/matrix_loader.sv
// Streams a framed sequence of signed elements into packed A (row-major) and
// transposed B operand buses, then sequences a single multiplier run.
//
// state   | meaning
// LOAD    | accepting elements, s_ready high
// FIRE    | one-cycle start pulse to the multiplier
// WAIT    | multiplier enabled, waiting for result or timeout
// DONE    | one-cycle completion pulse
module matrix_loader #(
  parameter int DWIDTH  = 8,
  parameter int ROW     = 3,
  parameter int COL     = 3,
  parameter int NUM     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DWIDTH-1:0]            s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [DWIDTH*ROW*NUM-1:0]    din_A,
  output logic [DWIDTH*COL*NUM-1:0]    din_B,
  output logic                         en,
  output logic                         trig,
  input  logic                         mul_out_vld,
  output logic                         done,
  output logic                         err_frame,
  output logic                         err_timeout,
  output logic                         busy
);

  localparam int NA = ROW * NUM;
  localparam int N  = NA + NUM * COL;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_WAIT, ST_DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   wait_cnt;
  logic            ready_q;
  logic            accept;
  logic            last_idx;
  logic            frame_ok;
  logic            frame_bad;
  logic            timeout_hit;

  assign accept      = s_valid && s_ready;
  assign last_idx    = (idx == IW'(N - 1));
  assign frame_ok    = accept && s_last && last_idx;
  assign frame_bad   = accept && (s_last ^ last_idx);
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD: if (frame_ok) state_nx = ST_FIRE;
      ST_FIRE: state_nx = ST_WAIT;
      ST_WAIT: begin
        // a result arriving on the timeout cycle still counts as completion
        if (mul_out_vld)      state_nx = ST_DONE;
        else if (timeout_hit) state_nx = ST_LOAD;
      end
      ST_DONE: state_nx = ST_LOAD;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    en      = 1'b0;
    trig    = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_LOAD: s_ready = ready_q;
      ST_FIRE: begin
        trig = 1'b1;
        en   = 1'b1;
        busy = 1'b1;
      end
      ST_WAIT: begin
        en   = 1'b1;
        busy = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // holds s_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      wait_cnt    <= '0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_frame   <= (state == ST_LOAD) && frame_bad;
      err_timeout <= (state == ST_WAIT) && !mul_out_vld && timeout_hit;
      if (state == ST_WAIT) wait_cnt <= wait_cnt + CW'(1);
      else                  wait_cnt <= '0;
      if (state == ST_LOAD && accept) begin
        if (s_last || last_idx) idx <= '0;
        else                    idx <= idx + IW'(1);
      end else if (state != ST_LOAD) begin
        idx <= '0;
      end
    end
  end

  // element idx maps to A[e] directly and to B^T for the second half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_A <= '0;
      din_B <= '0;
    end else if (state == ST_LOAD && accept) begin
      for (int e = 0; e < NA; e++) begin
        if (idx == IW'(e)) din_A[e*DWIDTH +: DWIDTH] <= s_data;
      end
      for (int k = 0; k < NUM; k++) begin
        for (int c = 0; c < COL; c++) begin
          if (idx == IW'(NA + k*COL + c))
            din_B[(c*NUM + k)*DWIDTH +: DWIDTH] <= s_data;
        end
      end
    end
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
- Parameters:
REQ-001 The block SHALL have parameter DWIDTH, default 8, meaning the signed element width in bits.
REQ-002 The block SHALL have parameter ROW, default 3, meaning the number of rows of A and C.
REQ-003 The block SHALL have parameter COL, default 3, meaning the number of columns of B and C.
REQ-004 The block SHALL have parameter NUM, default 3, meaning the number of columns of A and rows of B.
REQ-005 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum WAIT cycles before abort.
- Ports:
REQ-006 The block SHALL have clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-007 The block SHALL have rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have s_data, input, DWIDTH bits: element stream.
REQ-009 The block SHALL have s_valid, input, 1 bit: s_data is valid.
REQ-010 The block SHALL have s_last, input, 1 bit: marks the final element of a frame.
REQ-011 The block SHALL have s_ready, output, 1 bit: the element is accepted when s_valid&&s_ready.
REQ-012 The block SHALL have din_A, output, DWIDTH*ROW*NUM bits: A packed row-major.
REQ-013 The block SHALL have din_B, output, DWIDTH*COL*NUM bits: B transposed, packed row-major.
REQ-014 The block SHALL have en, output, 1 bit: multiplier enable.
REQ-015 The block SHALL have trig, output, 1 bit: one-cycle multiplier start pulse.
REQ-016 The block SHALL have mul_out_vld, input, 1 bit: multiplier result valid.
REQ-017 The block SHALL have done, output, 1 bit: one-cycle completion pulse.
REQ-018 The block SHALL have err_frame, output, 1 bit: one-cycle framing error pulse.
REQ-019 The block SHALL have err_timeout, output, 1 bit: one-cycle timeout pulse.
REQ-020 The block SHALL have busy, output, 1 bit: high in FIRE and WAIT.

Function
REQ-021 The frame length N SHALL be ROW*NUM+NUM*COL elements, 18 at the defaults, counted by an index idx running from 0 to N-1.
REQ-022 An accepted element at idx e<ROW*NUM SHALL be written to din_A[e*DWIDTH +: DWIDTH], i.e. A[e/NUM][e%NUM].
REQ-023 An accepted element at e>=ROW*NUM SHALL be treated as B row-major, with f=e-ROW*NUM, k=f/COL and c=f%COL, and written to din_B[(c*NUM+k)*DWIDTH +: DWIDTH].
REQ-024 The FSM SHALL have the states LOAD, FIRE, WAIT and DONE.
REQ-025 In LOAD, s_ready=1, en=0, and each accepted element SHALL increment idx.
REQ-026 An accept with s_last=1 at idx=N-1 SHALL move the FSM to FIRE next cycle.
REQ-027 An accept with s_last=1 at idx<N-1, or with s_last=0 at idx=N-1, SHALL pulse err_frame on the next cycle, reset idx to 0, and keep the FSM in LOAD; elements already written are not cleared.
REQ-028 FIRE SHALL last exactly one cycle with trig=1, en=1, s_ready=0, then move to WAIT.
REQ-029 In WAIT, en=1, trig=0 and s_ready=0, and a cycle counter SHALL start at 0.
REQ-030 When mul_out_vld=1 in WAIT, the FSM SHALL move to DONE.
REQ-031 When the WAIT counter reaches TIMEOUT-1 without mul_out_vld, the FSM SHALL pulse err_timeout and return to LOAD with en=0.
REQ-032 If mul_out_vld and the timeout occur in the same cycle, completion SHALL win.
REQ-033 DONE SHALL last one cycle with done=1, en=0, then return to LOAD with idx=0.
REQ-034 mul_out_vld outside WAIT SHALL be ignored.
REQ-035 din_A and din_B SHALL change only on accepts in LOAD and SHALL be stable throughout FIRE, WAIT and DONE.
REQ-036 The latency from the final accept to trig SHALL be 1 cycle, and from mul_out_vld to done SHALL be 1 cycle.
REQ-037 Data SHALL pass through unmodified, with no arithmetic on the element values.

Reset
REQ-038 While rst_n=0, asynchronously: FSM=LOAD, idx=0, WAIT counter=0, din_A=0, din_B=0, en=0, trig=0, done=0, err_frame=0, err_timeout=0, busy=0.
REQ-039 s_ready SHALL be 0 while rst_n=0 and SHALL become 1 in the first cycle after deassertion.
REQ-040 A reset during any state SHALL abort the frame, and the next frame SHALL start at idx=0.

Verification
REQ-041 The bench SHALL stream A=[1..9] and B=[10..18] row-major with s_last on the 18th element, and check: din_A byte i=i+1; din_B bytes 0..2=10,13,16; trig high exactly 1 cycle after the last accept; en=1.
REQ-042 The bench SHALL drive the full frame into a multiplier model, compare C against a reference matmul, see done 1 cycle after mul_out_vld, and see en=0 afterwards.
REQ-043 The bench SHALL assert s_last on the 5th element and check err_frame=1 for 1 cycle, no trig, and that a following good 18-element frame fires normally.
REQ-044 The bench SHALL hold mul_out_vld=0 after trig and check err_timeout at WAIT cycle 64, en=0, s_ready=1 the next cycle.
REQ-045 The bench SHALL pulse rst_n low during WAIT and check all outputs zero asynchronously, and that mul_out_vld arriving after reset produces no done.
REQ-046 The bench SHALL apply random s_valid gaps with values -128 and 127, and check packing is independent of the gaps and that trig is only asserted after 18 accepts.
